// File: rtl/e203_exu_longp_retire.sv
// Long-pipe retire stage: buffers LSU/NICE completions per OITF tag and
// retires them strictly in OITF order as a writeback, an exception, or a bare retire.
module e203_exu_longp_retire #(
    parameter  int OITF_DEPTH = 2,
    localparam int TAG_W      = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             lsu_rsp_valid,
    output logic             lsu_rsp_ready,
    input  logic [TAG_W-1:0] lsu_rsp_itag,
    input  logic [31:0]      lsu_rsp_wdat,
    input  logic             lsu_rsp_err,

    input  logic             nice_rsp_valid,
    output logic             nice_rsp_ready,
    input  logic [TAG_W-1:0] nice_rsp_itag,
    input  logic [31:0]      nice_rsp_wdat,
    input  logic             nice_rsp_err,

    input  logic             oitf_empty,
    input  logic [TAG_W-1:0] oitf_ret_ptr,
    input  logic [4:0]       oitf_ret_rdidx,
    input  logic             oitf_ret_rdwen,
    input  logic             oitf_ret_rdfpu,
    input  logic [31:0]      oitf_ret_pc,
    output logic             oitf_ret_ena,

    output logic             wbck_o_valid,
    input  logic             wbck_o_ready,
    output logic [31:0]      wbck_o_wdat,
    output logic [4:0]       wbck_o_rdidx,
    output logic             wbck_o_rdfpu,

    output logic             excp_o_valid,
    input  logic             excp_o_ready,
    output logic [31:0]      excp_o_pc
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds valid and its payload until that edge, and
    // ready may depend combinationally on the offered payload (tag).

    logic [OITF_DEPTH-1:0] slot_vld;
    logic [OITF_DEPTH-1:0] slot_err;
    logic [31:0]           slot_wdat [OITF_DEPTH];

    logic lsu_hsk;
    logic nice_hsk;
    logic head_vld;
    logic head_err;

    // LSU has priority on a same-tag collision, so NICE yields to a valid LSU offer.
    always_comb begin
        lsu_rsp_ready  = !slot_vld[lsu_rsp_itag];
        nice_rsp_ready = !slot_vld[nice_rsp_itag]
                         && !(lsu_rsp_valid && (lsu_rsp_itag == nice_rsp_itag));
        lsu_hsk        = lsu_rsp_valid && lsu_rsp_ready;
        nice_hsk       = nice_rsp_valid && nice_rsp_ready;
    end

    always_comb begin
        head_vld     = !oitf_empty && slot_vld[oitf_ret_ptr];
        head_err     = slot_err[oitf_ret_ptr];

        excp_o_valid = head_vld && head_err;
        excp_o_pc    = oitf_ret_pc;

        wbck_o_valid = head_vld && !head_err && oitf_ret_rdwen;
        wbck_o_wdat  = slot_wdat[oitf_ret_ptr];
        wbck_o_rdidx = oitf_ret_rdidx;
        wbck_o_rdfpu = oitf_ret_rdfpu;

        oitf_ret_ena = 1'b0;
        if (head_vld) begin
            if (head_err) begin
                oitf_ret_ena = excp_o_ready;
            end else if (oitf_ret_rdwen) begin
                oitf_ret_ena = wbck_o_ready;
            end else begin
                oitf_ret_ena = 1'b1;
            end
        end
    end

    // A fresh accept overrides a same-edge retire of the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (oitf_ret_ena && (oitf_ret_ptr == TAG_W'(i))) begin
                    slot_vld[i] <= 1'b0;
                end
                if ((lsu_hsk && (lsu_rsp_itag == TAG_W'(i)))
                    || (nice_hsk && (nice_rsp_itag == TAG_W'(i)))) begin
                    slot_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (lsu_hsk && (lsu_rsp_itag == TAG_W'(i))) begin
                slot_wdat[i] <= lsu_rsp_wdat;
                slot_err[i]  <= lsu_rsp_err;
            end else if (nice_hsk && (nice_rsp_itag == TAG_W'(i))) begin
                slot_wdat[i] <= nice_rsp_wdat;
                slot_err[i]  <= nice_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_longp_retire.sv
// Directed bench for the long-pipe retire stage: a small OITF model feeds the
// head entry, a retire scoreboard checks every oitf_ret_ena against exp_q.
module tb_e203_exu_longp_retire;

    localparam int W = 41;

    logic        clk;
    logic        rst;
    logic        lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_itag, lsu_rsp_err;
    logic [31:0] lsu_rsp_wdat;
    logic        nice_rsp_valid, nice_rsp_ready, nice_rsp_itag, nice_rsp_err;
    logic [31:0] nice_rsp_wdat;
    logic        oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
    logic [4:0]  oitf_ret_rdidx;
    logic [31:0] oitf_ret_pc;
    logic        wbck_o_valid, wbck_o_ready, wbck_o_rdfpu;
    logic [31:0] wbck_o_wdat;
    logic [4:0]  wbck_o_rdidx;
    logic        excp_o_valid, excp_o_ready;
    logic [31:0] excp_o_pc;

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    // OITF model: entries allocated by the stimulus, retired on oitf_ret_ena.
    logic [7:0]  alloc_cnt = '0;
    logic [7:0]  ret_cnt   = '0;
    logic        ent_rdwen [2];
    logic        ent_rdfpu [2];
    logic [4:0]  ent_rdidx [2];
    logic [31:0] ent_pc    [2];

    assign oitf_empty     = (alloc_cnt == ret_cnt);
    assign oitf_ret_ptr   = ret_cnt[0];
    assign oitf_ret_rdwen = ent_rdwen[oitf_ret_ptr];
    assign oitf_ret_rdfpu = ent_rdfpu[oitf_ret_ptr];
    assign oitf_ret_rdidx = ent_rdidx[oitf_ret_ptr];
    assign oitf_ret_pc    = ent_pc[oitf_ret_ptr];

    always @(posedge clk) begin
        if (oitf_ret_ena === 1'b1) ret_cnt <= ret_cnt + 8'd1;
    end

    e203_exu_longp_retire #(.OITF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_itag(lsu_rsp_itag), .lsu_rsp_wdat(lsu_rsp_wdat), .lsu_rsp_err(lsu_rsp_err),
        .nice_rsp_valid(nice_rsp_valid), .nice_rsp_ready(nice_rsp_ready),
        .nice_rsp_itag(nice_rsp_itag), .nice_rsp_wdat(nice_rsp_wdat), .nice_rsp_err(nice_rsp_err),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_pc(oitf_ret_pc),
        .oitf_ret_ena(oitf_ret_ena),
        .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
        .wbck_o_rdidx(wbck_o_rdidx), .wbck_o_rdfpu(wbck_o_rdfpu),
        .excp_o_valid(excp_o_valid), .excp_o_ready(excp_o_ready), .excp_o_pc(excp_o_pc)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire record: {kind(0 none,1 wbck,2 excp), ptr, rdfpu, rdidx, data}
    function automatic logic [W-1:0] rec(input logic [1:0] kind, input logic ptr,
                                         input logic fpu, input logic [4:0] idx,
                                         input logic [31:0] d);
        return {kind, ptr, fpu, idx, d};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && (oitf_ret_ena === 1'b1)) begin
            if (excp_o_valid && wbck_o_valid)
                mon_act = rec(2'd3, oitf_ret_ptr, 1'b0, 5'd0, 32'd0);
            else if (excp_o_valid)
                mon_act = rec(2'd2, oitf_ret_ptr, 1'b0, 5'd0, excp_o_pc);
            else if (wbck_o_valid)
                mon_act = rec(2'd1, oitf_ret_ptr, wbck_o_rdfpu, wbck_o_rdidx, wbck_o_wdat);
            else
                mon_act = rec(2'd0, oitf_ret_ptr, 1'b0, 5'd0, 32'd0);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL retire_unexpected: got %h, required no retire", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL retire_record: got %h, required %h", mon_act, mon_exp);
                end
            end
        end
    end

    // Driver tasks
    task automatic chk1(input string n, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b, required %b", n, a, e);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, required %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic rdwen, input logic fpu, input logic [4:0] idx,
                         input logic [31:0] pc);
        ent_rdwen[alloc_cnt[0]] = rdwen;
        ent_rdfpu[alloc_cnt[0]] = fpu;
        ent_rdidx[alloc_cnt[0]] = idx;
        ent_pc[alloc_cnt[0]]    = pc;
        alloc_cnt = alloc_cnt + 8'd1;
    endtask

    task automatic lsu_drive(input logic tag, input logic [31:0] d, input logic e);
        lsu_rsp_valid = 1'b1; lsu_rsp_itag = tag; lsu_rsp_wdat = d; lsu_rsp_err = e;
    endtask

    task automatic nice_drive(input logic tag, input logic [31:0] d, input logic e);
        nice_rsp_valid = 1'b1; nice_rsp_itag = tag; nice_rsp_wdat = d; nice_rsp_err = e;
    endtask

    initial begin
        rst = 1'b1;
        lsu_rsp_valid = 1'b0; lsu_rsp_itag = 1'b0; lsu_rsp_wdat = '0; lsu_rsp_err = 1'b0;
        nice_rsp_valid = 1'b0; nice_rsp_itag = 1'b0; nice_rsp_wdat = '0; nice_rsp_err = 1'b0;
        wbck_o_ready = 1'b1; excp_o_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ent_rdwen[i] = 1'b0; ent_rdfpu[i] = 1'b0; ent_rdidx[i] = '0; ent_pc[i] = '0;
        end

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk1("rst_lsu_ready", lsu_rsp_ready, 1'b1);
        chk1("rst_nice_ready", nice_rsp_ready, 1'b1);
        chk1("rst_wbck_valid", wbck_o_valid, 1'b0);
        chk1("rst_excp_valid", excp_o_valid, 1'b0);
        chk1("rst_ret_ena", oitf_ret_ena, 1'b0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // In-order writeback, tag 0
        alloc(1'b1, 1'b0, 5'd1, 32'h0000_0100);
        exp_q.push_back(rec(2'd1, 1'b0, 1'b0, 5'd1, 32'hDEADBEEF));
        lsu_drive(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk1("wb_lsu_ready", lsu_rsp_ready, 1'b1);
        chk1("wb_no_early_ret", oitf_ret_ena, 1'b0);
        tick();
        lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("wb_valid", wbck_o_valid, 1'b1);
        chk32("wb_wdat", wbck_o_wdat, 32'hDEADBEEF);
        chk32("wb_rdidx", 32'(wbck_o_rdidx), 32'd1);
        chk1("wb_ret_ena", oitf_ret_ena, 1'b1);
        tick();
        @(negedge clk);
        chk1("wb_after_valid", wbck_o_valid, 1'b0);
        chk1("wb_after_ret_ena", oitf_ret_ena, 1'b0);
        chk1("wb_slot0_freed", lsu_rsp_ready, 1'b1);
        tick();

        // No-write completion, tag 1
        alloc(1'b0, 1'b0, 5'd12, 32'h0000_0200);
        exp_q.push_back(rec(2'd0, 1'b1, 1'b0, 5'd0, 32'd0));
        lsu_drive(1'b1, 32'h0000_0055, 1'b0);
        tick();
        lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("nw_ret_ena", oitf_ret_ena, 1'b1);
        chk1("nw_wbck_valid", wbck_o_valid, 1'b0);
        chk1("nw_excp_valid", excp_o_valid, 1'b0);
        tick();
        @(negedge clk);
        chk1("nw_after_ret_ena", oitf_ret_ena, 1'b0);
        tick();

        // Out-of-order completion: NICE tag 1 first, LSU tag 0 later
        alloc(1'b1, 1'b0, 5'd3, 32'h0000_0300);
        alloc(1'b1, 1'b0, 5'd4, 32'h0000_0304);
        exp_q.push_back(rec(2'd1, 1'b0, 1'b0, 5'd3, 32'hA0A0A0A0));
        exp_q.push_back(rec(2'd1, 1'b1, 1'b0, 5'd4, 32'hB0B0B0B0));
        nice_drive(1'b1, 32'hB0B0B0B0, 1'b0);
        @(negedge clk);
        chk1("ooo_nice_ready", nice_rsp_ready, 1'b1);
        tick();
        nice_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("ooo_nice_ready_busy", nice_rsp_ready, 1'b0);
            chk1("ooo_head_wait", oitf_ret_ena, 1'b0);
            tick();
        end
        lsu_drive(1'b0, 32'hA0A0A0A0, 1'b0);
        @(negedge clk);
        chk1("ooo_lsu_ready", lsu_rsp_ready, 1'b1);
        tick();
        lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("ooo_ret0", oitf_ret_ena, 1'b1);
        chk32("ooo_wdat0", wbck_o_wdat, 32'hA0A0A0A0);
        tick();
        @(negedge clk);
        chk1("ooo_ret1", oitf_ret_ena, 1'b1);
        chk32("ooo_wdat1", wbck_o_wdat, 32'hB0B0B0B0);
        tick();
        @(negedge clk);
        chk1("ooo_done", oitf_ret_ena, 1'b0);
        chk1("ooo_slot1_freed", nice_rsp_ready, 1'b1);
        tick();

        // Error path with exception back-pressure
        alloc(1'b1, 1'b0, 5'd9, 32'h8000_0100);
        exp_q.push_back(rec(2'd2, 1'b0, 1'b0, 5'd0, 32'h8000_0100));
        lsu_drive(1'b0, 32'h1234_5678, 1'b1);
        tick();
        lsu_rsp_valid = 1'b0; lsu_rsp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("err_excp_valid", excp_o_valid, 1'b1);
            chk32("err_excp_pc", excp_o_pc, 32'h8000_0100);
            chk1("err_wbck_valid", wbck_o_valid, 1'b0);
            chk1("err_no_ret", oitf_ret_ena, 1'b0);
            tick();
        end
        excp_o_ready = 1'b1;
        @(negedge clk);
        chk1("err_ret_ena", oitf_ret_ena, 1'b1);
        tick();
        excp_o_ready = 1'b0;
        @(negedge clk);
        chk1("err_after_excp", excp_o_valid, 1'b0);
        chk1("err_after_ret", oitf_ret_ena, 1'b0);
        tick();

        // FPU writeback with writeback back-pressure, tag 1
        alloc(1'b1, 1'b1, 5'd31, 32'h0000_0400);
        exp_q.push_back(rec(2'd1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF));
        wbck_o_ready = 1'b0;
        nice_drive(1'b1, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        chk1("fpu_nice_ready", nice_rsp_ready, 1'b1);
        tick();
        nice_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("fpu_wbck_valid", wbck_o_valid, 1'b1);
            chk1("fpu_rdfpu", wbck_o_rdfpu, 1'b1);
            chk32("fpu_rdidx", 32'(wbck_o_rdidx), 32'd31);
            chk32("fpu_wdat", wbck_o_wdat, 32'hFFFFFFFF);
            chk1("fpu_no_ret", oitf_ret_ena, 1'b0);
            tick();
        end
        wbck_o_ready = 1'b1;
        @(negedge clk);
        chk1("fpu_ret_ena", oitf_ret_ena, 1'b1);
        tick();
        @(negedge clk);
        chk1("fpu_after_ret", oitf_ret_ena, 1'b0);
        tick();

        // Same-tag collision on tag 0: LSU wins, NICE lands after slot 0 retires
        alloc(1'b1, 1'b0, 5'd7, 32'h0000_0500);
        alloc(1'b0, 1'b0, 5'd0, 32'h0000_0504);
        exp_q.push_back(rec(2'd1, 1'b0, 1'b0, 5'd7, 32'h1111_0000));
        lsu_drive(1'b0, 32'h1111_0000, 1'b0);
        nice_drive(1'b0, 32'h2222_0000, 1'b0);
        @(negedge clk);
        chk1("col_lsu_ready", lsu_rsp_ready, 1'b1);
        chk1("col_nice_ready", nice_rsp_ready, 1'b0);
        tick();
        lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("col_nice_blocked", nice_rsp_ready, 1'b0);
        chk1("col_ret_a", oitf_ret_ena, 1'b1);
        tick();
        alloc(1'b1, 1'b0, 5'd8, 32'h0000_0508);
        exp_q.push_back(rec(2'd0, 1'b1, 1'b0, 5'd0, 32'd0));
        exp_q.push_back(rec(2'd1, 1'b0, 1'b0, 5'd8, 32'h2222_0000));
        @(negedge clk);
        chk1("col_nice_ready_late", nice_rsp_ready, 1'b1);
        chk1("col_head_b_wait", oitf_ret_ena, 1'b0);
        tick();
        nice_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("col_in_order", oitf_ret_ena, 1'b0);
        tick();
        lsu_drive(1'b1, 32'h0000_0000, 1'b0);
        @(negedge clk);
        chk1("col_lsu1_ready", lsu_rsp_ready, 1'b1);
        tick();
        lsu_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("col_ret_b", oitf_ret_ena, 1'b1);
        chk1("col_ret_b_nowb", wbck_o_valid, 1'b0);
        tick();
        @(negedge clk);
        chk1("col_ret_c", oitf_ret_ena, 1'b1);
        chk32("col_wdat_c", wbck_o_wdat, 32'h2222_0000);
        tick();
        @(negedge clk);
        chk1("col_done", oitf_ret_ena, 1'b0);
        tick();

        // Reset mid-operation with both slots full
        wbck_o_ready = 1'b0;
        alloc(1'b1, 1'b0, 5'd10, 32'h0000_0600);
        alloc(1'b1, 1'b0, 5'd11, 32'h0000_0604);
        lsu_drive(1'b0, 32'h0C0C_0C0C, 1'b0);
        nice_drive(1'b1, 32'h0D0D_0D0D, 1'b0);
        @(negedge clk);
        chk1("mr_dual_lsu_ready", lsu_rsp_ready, 1'b1);
        chk1("mr_dual_nice_ready", nice_rsp_ready, 1'b1);
        tick();
        lsu_rsp_valid = 1'b0; nice_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("mr_head_wbck", wbck_o_valid, 1'b1);
        chk1("mr_held", oitf_ret_ena, 1'b0);
        chk1("mr_slot0_full", lsu_rsp_ready, 1'b0);
        chk1("mr_slot1_full", nice_rsp_ready, 1'b0);
        tick();
        rst = 1'b1;
        alloc_cnt = ret_cnt;
        @(negedge clk);
        chk1("mr_empty_no_ret", oitf_ret_ena, 1'b0);
        chk1("mr_empty_no_wbck", wbck_o_valid, 1'b0);
        tick();
        rst = 1'b0;
        wbck_o_ready = 1'b1;
        alloc(1'b1, 1'b0, 5'd10, 32'h0000_0700);
        alloc(1'b1, 1'b0, 5'd11, 32'h0000_0704);
        @(negedge clk);
        chk1("mr_post_ret", oitf_ret_ena, 1'b0);
        chk1("mr_post_wbck", wbck_o_valid, 1'b0);
        chk1("mr_post_excp", excp_o_valid, 1'b0);
        chk1("mr_post_lsu0", lsu_rsp_ready, 1'b1);
        chk1("mr_post_nice1", nice_rsp_ready, 1'b1);
        lsu_rsp_itag = 1'b1; nice_rsp_itag = 1'b0;
        #1;
        chk1("mr_post_lsu1", lsu_rsp_ready, 1'b1);
        chk1("mr_post_nice0", nice_rsp_ready, 1'b1);
        repeat (3) tick();

        // Final report
        mon_en = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL retire_missing: got %0d retires outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
